// File: rtl/lsu_pkg.sv
// Shared LSU types, funct3 encodings, byte-enable and load-extension helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {REG_NONE, REG_DMEM, REG_OUT, REG_IN} region_e;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h000000, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0000, h};
      F3_W:    r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_dmem_bank.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
module lsu_dmem_bank
  import lsu_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-3:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  localparam int DEPTH = 2 ** (AW - 2);

  logic [31:0] mem_r [DEPTH];

  // byte-lane writes and registered read; contents are deliberately never reset
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) begin
        mem_r[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_o <= mem_r[addr_i];
  end

endmodule

// File: rtl/lsu_mmio_gen.sv
// Handshaked load-store unit: data RAM plus N_IN input / N_OUT output MMIO words.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses instead of aligning them down.
module lsu_mmio_gen
  import lsu_pkg::*;
#(
  parameter int          DMEM_AW   = 13,
  parameter logic [31:0] DMEM_BASE = 32'h0000_2000,
  parameter int          N_OUT     = 16,
  parameter logic [31:0] OUT_BASE  = 32'h0000_7000,
  parameter int          N_IN      = 8,
  parameter logic [31:0] IN_BASE   = 32'h0000_7800
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  input  logic [32*N_IN-1:0]    io_in_i,
  output logic [32*N_OUT-1:0]   io_out_o
);

  localparam int          OUT_IW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int          IN_IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [31:0] OUT_END = OUT_BASE + 32'(N_OUT) * 32'd4;
  localparam logic [31:0] IN_END  = IN_BASE + 32'(N_IN) * 32'd4;

  state_e                  state_r, state_next_s;
  logic                    ready_r, rsp_valid_r, rsp_err_r, rsp_dmem_r;
  logic                    we_r, mis_r;
  logic [2:0]              f3_r;
  logic [31:0]             addr_r, wdata_r, mmio_word_r;
  logic [N_OUT-1:0][31:0]  io_out_r;
  logic [N_IN-1:0][31:0]   in_shadow_r;

  logic                    accept_s, mis_s, err_s, dmem_we_s, out_we_s;
  logic [31:0]             eff_addr_s, wlane_s, dmem_rdata_s, rsp_word_s;
  logic [3:0]              be_s;
  region_e                 region_s;
  logic [OUT_IW-1:0]       out_idx_s;
  logic [IN_IW-1:0]        in_idx_s;

  assign accept_s    = req_valid_i && ready_r;
  assign req_ready_o = ready_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_err_o   = rsp_err_r;
  assign io_out_o    = io_out_r;

`ifdef LSU_MISALIGN_TRAP_EN
  // misaligned halves/words are flagged; the address is kept as issued
  always_comb begin
    mis_s = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
            ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    eff_addr_s = req_addr_i;
  end
`else
  // misaligned halves/words silently drop the low offset bits
  always_comb begin
    mis_s = 1'b0;
    case (req_funct3_i[1:0])
      2'b01:   eff_addr_s = {req_addr_i[31:1], 1'b0};
      2'b10:   eff_addr_s = {req_addr_i[31:2], 2'b00};
      default: eff_addr_s = req_addr_i;
    endcase
  end
`endif

  // request latch on handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      mis_r   <= 1'b0;
    end else if (accept_s) begin
      we_r    <= req_we_i;
      f3_r    <= req_funct3_i;
      addr_r  <= eff_addr_s;
      wdata_r <= req_wdata_i;
      mis_r   <= mis_s;
    end
  end

  assign out_idx_s = OUT_IW'((addr_r - OUT_BASE) >> 2'd2);
  assign in_idx_s  = IN_IW'((addr_r - IN_BASE) >> 2'd2);
  assign be_s      = be_gen(f3_r, addr_r[1:0]);

  // region decode, error classification and store lane replication
  always_comb begin
    if (addr_r[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW]) begin
      region_s = REG_DMEM;
    end else if ((addr_r >= OUT_BASE) && (addr_r < OUT_END)) begin
      region_s = REG_OUT;
    end else if ((addr_r >= IN_BASE) && (addr_r < IN_END)) begin
      region_s = REG_IN;
    end else begin
      region_s = REG_NONE;
    end
    err_s = !f3_legal(we_r, f3_r) || (region_s == REG_NONE) ||
            (we_r && (region_s == REG_IN)) || mis_r;
    case (f3_r[1:0])
      2'b00:   wlane_s = {4{wdata_r[7:0]}};
      2'b01:   wlane_s = {2{wdata_r[15:0]}};
      default: wlane_s = wdata_r;
    endcase
  end

  assign dmem_we_s = (state_r == S_ACCESS) && we_r && !err_s && (region_s == REG_DMEM);
  assign out_we_s  = (state_r == S_ACCESS) && we_r && !err_s && (region_s == REG_OUT);

  lsu_dmem_bank #(.AW(DMEM_AW)) u_dmem (
    .clk_i   (clk_i),
    .we_i    (dmem_we_s),
    .be_i    (be_s),
    .addr_i  (addr_r[DMEM_AW-1:2]),
    .wdata_i (wlane_s),
    .rdata_o (dmem_rdata_s)
  );

  // output registers and one-cycle-delayed input shadow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      io_out_r    <= '0;
      in_shadow_r <= '0;
    end else begin
      in_shadow_r <= io_in_i;
      for (int i = 0; i < 4; i++) begin
        if (out_we_s && be_s[i]) begin
          io_out_r[out_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
        end
      end
    end
  end

  // state register; ready and response-valid are registered from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= S_IDLE;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      ready_r     <= (state_next_s != S_ACCESS);
      rsp_valid_r <= (state_next_s == S_RESP);
    end
  end

  // next-state logic
  always_comb begin
    state_next_s = S_IDLE;
    case (state_r)
      S_IDLE:   if (accept_s) state_next_s = S_ACCESS; else state_next_s = S_IDLE;
      S_ACCESS: state_next_s = S_RESP;
      S_RESP:   if (accept_s) state_next_s = S_ACCESS; else state_next_s = S_IDLE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // capture error status and MMIO read word at the end of ACCESS
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_err_r   <= 1'b0;
      rsp_dmem_r  <= 1'b0;
      mmio_word_r <= 32'h0000_0000;
    end else if (state_r == S_ACCESS) begin
      rsp_err_r  <= err_s;
      rsp_dmem_r <= (region_s == REG_DMEM);
      case (region_s)
        REG_OUT: mmio_word_r <= io_out_r[out_idx_s];
        REG_IN:  mmio_word_r <= in_shadow_r[in_idx_s];
        default: mmio_word_r <= 32'h0000_0000;
      endcase
    end else begin
      rsp_err_r <= 1'b0;
    end
  end

  assign rsp_word_s = rsp_dmem_r ? dmem_rdata_s : mmio_word_r;

  // load data is only presented for error-free load responses
  always_comb begin
    if (rsp_valid_r && !rsp_err_r && !we_r) begin
      rsp_rdata_o = ld_extend(f3_r, addr_r[1:0], rsp_word_s);
    end else begin
      rsp_rdata_o = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_lsu_mmio_gen.sv
// Self-checking bench for lsu_mmio_gen: directed vector table, corner sequences, random vs byte-level model.
module tb_lsu_mmio_gen;

  localparam int N_OUT = 16;
  localparam int N_IN  = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid, req_we;
  logic [2:0]          req_f3;
  logic [31:0]         req_addr, req_wdata;
  logic                ready, rsp_valid, rsp_err;
  logic [31:0]         rsp_rdata;
  logic [32*N_IN-1:0]  io_in;
  logic [32*N_OUT-1:0] io_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mmio_gen dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_f3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .io_in_i      (io_in),
    .io_out_o     (io_out)
  );

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          er;
  } vec_t;

  vec_t        tab[$];
  logic [7:0]  dmem_m [logic [31:0]];
  logic [7:0]  out_m  [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [32*N_OUT-1:0] exp);
    bit shown;
    shown = 1'b0;
    n_chk++;
    if (io_out !== exp) begin
      n_fail++;
      for (int k = 0; k < N_OUT; k++) begin
        if (!shown && (io_out[32*k +: 32] !== exp[32*k +: 32])) begin
          $display("FAIL %s: io_out word %0d got %08h, expected %08h",
                   name, k, io_out[32*k +: 32], exp[32*k +: 32]);
          shown = 1'b1;
        end
      end
    end
  endtask

  task automatic add(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd, input bit er);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.er = er;
    tab.push_back(v);
  endtask

  // issue one request and wait (bounded) for its response; lat counts cycles after accept
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output bit er,
                        output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!ready && g < 8) begin
      @(negedge clk);
      g++;
    end
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        rd = rsp_rdata;
        er = rsp_err;
        break;
      end
    end
  endtask

  task automatic run_chk(input string nm, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit exp_er, input bit chk_rd);
    logic [31:0] rd;
    bit          er;
    int          lat;
    do_req(we, f3, addr, wd, rd, er, lat);
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_err"}, {31'b0, er}, {31'b0, exp_er});
    if (chk_rd) chk({nm, "_rdata"}, rd, exp_rd);
    @(negedge clk);
    chk({nm, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  // byte-level reference: a request is a list of size bytes in a region map
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output bit er,
                                output bit known);
    int          size, rg;
    bit          legal, mis, trap;
    logic [31:0] a, p, v;
    logic [7:0]  b;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    mis   = (addr % 32'(size)) != 32'd0;
    a     = addr - (addr % 32'(size));
`ifdef LSU_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    if (a >= 32'h2000 && a < 32'h4000) rg = 1;
    else if (a >= 32'h7000 && a < 32'h7040) rg = 2;
    else if (a >= 32'h7800 && a < 32'h7820) rg = 3;
    else rg = 0;
    er = !legal || rg == 0 || (we && rg == 3) || (trap && mis);
    rd = 32'h0; known = 1'b1;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) begin
          p = a + 32'(i);
          if (rg == 1) dmem_m[p] = wd[8*i +: 8];
          else out_m[p - 32'h7000] = wd[8*i +: 8];
        end
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) begin
          p = a + 32'(i);
          if (rg == 1) begin
            if (dmem_m.exists(p)) b = dmem_m[p];
            else begin b = 8'h00; known = 1'b0; end
          end else if (rg == 2) b = out_m[p - 32'h7000];
          else b = io_in[8*(p - 32'h7800) +: 8];
          v = v | (32'(b) << (8*i));
        end
        if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]         rd, exp_rd, addr, wd;
    logic [32*N_OUT-1:0] exp_out;
    logic [2:0]          f3;
    bit                  er, exp_er, known, we;
    int                  lat, seen;
    int                  unmapped[8];

    req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    io_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk_out("rst_io_out", '0);
    rst = 1'b0;
    @(negedge clk);

    // SH to output word 1 becomes visible the cycle after ACCESS
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b001; req_addr = 32'h7004; req_wdata = 32'h1234BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("sh_out_during_access", io_out[63:32], 32'h0);
    chk("sh_ready_access", {31'b0, ready}, 32'd0);
    @(negedge clk);
    chk("sh_out_after_access", io_out[63:32], 32'h0000BEEF);
    chk("sh_rsp_valid", {31'b0, rsp_valid}, 32'd1);

    io_in[95:64] = 32'hCAFEF00D;
    @(negedge clk);

    add(1, 3'b010, 32'h2000, 32'h12345678, 32'h0, 0);
    add(0, 3'b010, 32'h2000, 32'h0, 32'h12345678, 0);
    add(1, 3'b000, 32'h2003, 32'h000000AA, 32'h0, 0);
    add(0, 3'b000, 32'h2003, 32'h0, 32'hFFFFFFAA, 0);
    add(0, 3'b100, 32'h2003, 32'h0, 32'h000000AA, 0);
    add(0, 3'b010, 32'h2000, 32'h0, 32'hAA345678, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    add(0, 3'b010, 32'h2002, 32'h0, 32'h0, 1);
`else
    add(0, 3'b010, 32'h2002, 32'h0, 32'hAA345678, 0);
`endif
    add(0, 3'b001, 32'h2002, 32'h0, 32'hFFFFAA34, 0);
    add(0, 3'b000, 32'h2001, 32'h0, 32'h00000056, 0);
    add(0, 3'b101, 32'h7004, 32'h0, 32'h0000BEEF, 0);
    add(0, 3'b010, 32'h7808, 32'h0, 32'hCAFEF00D, 0);
    add(1, 3'b010, 32'h7808, 32'h55555555, 32'h0, 1);
    add(0, 3'b010, 32'h7808, 32'h0, 32'hCAFEF00D, 0);
    add(0, 3'b010, 32'h5000, 32'h0, 32'h0, 1);
    add(0, 3'b010, 32'h4000, 32'h0, 32'h0, 1);
    add(0, 3'b010, 32'h7040, 32'h0, 32'h0, 1);
    add(0, 3'b010, 32'h7820, 32'h0, 32'h0, 1);
    add(1, 3'b010, 32'h3FFC, 32'hDEADBEEF, 32'h0, 0);
    add(0, 3'b010, 32'h3FFC, 32'h0, 32'hDEADBEEF, 0);
    add(1, 3'b100, 32'h2000, 32'hFFFFFFFF, 32'h0, 1);
    add(0, 3'b010, 32'h2000, 32'h0, 32'hAA345678, 0);
    add(0, 3'b011, 32'h2000, 32'h0, 32'h0, 1);
    add(1, 3'b110, 32'h7000, 32'hFFFFFFFF, 32'h0, 1);
    add(0, 3'b010, 32'h7000, 32'h0, 32'h0, 0);
    for (int i = 0; i < tab.size(); i++) begin
      run_chk($sformatf("vec%0d", i), tab[i].we, tab[i].f3, tab[i].addr, tab[i].wd,
              tab[i].rd, tab[i].er, 1'b1);
    end

    // back-to-back: second request held through ACCESS, accepted in RESP
    @(negedge clk);
    chk("b2b_ready_idle", {31'b0, ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h2010; req_wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_ready_access", {31'b0, ready}, 32'd0);
    req_we = 1'b0; req_addr = 32'h2010; req_wdata = 32'h0;
    @(negedge clk);
    chk("b2b_rsp1_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_ready_resp", {31'b0, ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_gap", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_rsp2_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_rsp2_rdata", rsp_rdata, 32'h0BADF00D);

    // reset during ACCESS of a store to output word 0
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h7000; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    chk("abort_out_w0", io_out[31:0], 32'h0);
    chk_out("abort_io_out", '0);

    // random phase against the byte-level model
    for (int k = 0; k < 64; k++) out_m[k] = 8'h00;
    for (int k = 0; k < 16; k++) begin
      model(1'b1, 3'b010, 32'h2000 + 32'(4*k), 32'h0, exp_rd, exp_er, known);
      run_chk($sformatf("init%0d", k), 1'b1, 3'b010, 32'h2000 + 32'(4*k), 32'h0, 32'h0, 1'b0, 1'b1);
    end
    unmapped[0] = 32'h0000_0000; unmapped[1] = 32'h0000_1FFC; unmapped[2] = 32'h0000_4000;
    unmapped[3] = 32'h0000_5000; unmapped[4] = 32'h0000_7040; unmapped[5] = 32'h0000_77FC;
    unmapped[6] = 32'h0000_7820; unmapped[7] = 32'hFFFF_FFFC;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < N_IN; k++) io_in[32*k +: 32] = $urandom;
      end
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 3))
        0:       addr = 32'h2000 + 32'($urandom_range(0, 63));
        1:       addr = 32'h7000 + 32'($urandom_range(0, 63));
        2:       addr = 32'h7800 + 32'($urandom_range(0, 31));
        default: addr = 32'(unmapped[$urandom_range(0, 7)]);
      endcase
      model(we, f3, addr, wd, exp_rd, exp_er, known);
      do_req(we, f3, addr, wd, rd, er, lat);
      chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'd2);
      chk($sformatf("rnd%0d_err", t), {31'b0, er}, {31'b0, exp_er});
      if (known) chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      for (int k = 0; k < 64; k++) exp_out[8*k +: 8] = out_m[k];
      chk_out($sformatf("rnd%0d_io_out", t), exp_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
